// File: rtl/buf_lru_alloc_ctrl.sv
// buf_lru_alloc_ctrl
// Shares four buffers between two requesters. Each request tag is looked up in a
// 4-entry tag table. A hit returns the buffer number. A miss picks a victim,
// runs a fill handshake with the backing store, and then returns the victim.
// Replacement uses a 6-bit pairwise LRU; each bit is 1 when the lower index of
// its pair is the older one.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[1:0]        per-requester request
//   req_tag0/1            request tags
//   req_ready[1:0]        one-hot grant, combinational, only in IDLE
//   flush                 invalidate all tag entries (deferred while busy)
//   rsp_valid/id/buf/hit  one-cycle response strobe plus held payload
//   fill_req/buf/tag      fill request, held until fill_done
//   fill_done             fill completion, only looked at in FILL
//   busy                  high in every state except IDLE
module buf_lru_alloc_ctrl #(
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   input  logic [TAG_W-1:0] req_tag0,
   input  logic [TAG_W-1:0] req_tag1,
   output logic [1:0]       req_ready,
   input  logic             flush,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [1:0]       rsp_buf,
   output logic             rsp_hit,
   output logic             fill_req,
   output logic [1:0]       fill_buf,
   output logic [TAG_W-1:0] fill_tag,
   input  logic             fill_done,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

   state_t           state;
   logic [3:0]       valid;
   logic [TAG_W-1:0] tags [4];
   logic [5:0]       lru;
   logic             rr_pri;      // requester favoured when both request
   logic             flush_pend;
   logic             id_q;
   logic [TAG_W-1:0] tag_q;
   logic             flush_now;
   logic             hit;
   logic [1:0]       hit_idx;
   logic [1:0]       free_idx;
   logic [1:0]       victim;

   // Bits: 5=(0,1) 4=(0,2) 3=(0,3) 2=(1,2) 1=(1,3) 0=(2,3).
   // Touching k makes k the newest buffer in each of its three pairs.
   function automatic logic [5:0] lru_touch(input logic [5:0] l, input logic [1:0] k);
      logic [5:0] n;
      n = l;
      case (k)
         2'd0:    n[5:3] = 3'b000;
         2'd1:    begin n[5] = 1'b1; n[2:1] = 2'b00; end
         2'd2:    begin n[4] = 1'b1; n[2] = 1'b1; n[0] = 1'b0; end
         default: begin n[3] = 1'b1; n[1:0] = 2'b11; end
      endcase
      return n;
   endfunction

   // The oldest buffer is older in all three of its pairs.
   // An unreachable code falls back to buffer 0.
   function automatic logic [1:0] lru_oldest(input logic [5:0] l);
      if (l[5] & l[4] & l[3])         return 2'd0;
      else if (!l[5] & l[2] & l[1])   return 2'd1;
      else if (!l[4] & !l[2] & l[0])  return 2'd2;
      else if (!l[3] & !l[1] & !l[0]) return 2'd3;
      else                            return 2'd0;
   endfunction

   assign flush_now = flush_pend | flush;

   // Hit lookup and lowest free entry. The loop runs from high to low
   // index so that the lowest index wins.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = 2'd0;
      free_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (valid[i] && tags[i] == tag_q) begin
            hit     = 1'b1;
            hit_idx = 2'(i);
         end
         if (!valid[i]) free_idx = 2'(i);
      end
      victim = (&valid) ? lru_oldest(lru) : free_idx;
   end

   // A pending or incoming flush takes the IDLE cycle, so no grant is made then.
   always_comb begin
      req_ready = 2'b00;
      if (state == IDLE && !flush_now) begin
         case (req_valid)
            2'b01:   req_ready = 2'b01;
            2'b10:   req_ready = 2'b10;
            2'b11:   req_ready = rr_pri ? 2'b10 : 2'b01;
            default: req_ready = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         valid      <= 4'b0000;
         for (int i = 0; i < 4; i++) tags[i] <= '0;
         lru        <= 6'b111111;
         rr_pri     <= 1'b0;
         flush_pend <= 1'b0;
         id_q       <= 1'b0;
         tag_q      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_buf    <= 2'd0;
         rsp_hit    <= 1'b0;
         fill_req   <= 1'b0;
         fill_buf   <= 2'd0;
         fill_tag   <= '0;
         busy       <= 1'b0;
      end else begin
         if (flush && state != IDLE) flush_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (flush_now) begin
                  valid      <= 4'b0000;
                  flush_pend <= 1'b0;
               end else if (|req_ready) begin
                  tag_q  <= req_ready[1] ? req_tag1 : req_tag0;
                  id_q   <= req_ready[1];
                  rr_pri <= ~req_ready[1];
                  busy   <= 1'b1;
                  state  <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  lru       <= lru_touch(lru, hit_idx);
                  rsp_valid <= 1'b1;
                  rsp_id    <= id_q;
                  rsp_buf   <= hit_idx;
                  rsp_hit   <= 1'b1;
                  state     <= RESP;
               end else begin
                  fill_req <= 1'b1;
                  fill_buf <= victim;
                  fill_tag <= tag_q;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (fill_done) begin
                  valid[fill_buf] <= 1'b1;
                  tags[fill_buf]  <= fill_tag;
                  lru             <= lru_touch(lru, fill_buf);
                  fill_req        <= 1'b0;
                  rsp_valid       <= 1'b1;
                  rsp_id          <= id_q;
                  rsp_buf         <= fill_buf;
                  rsp_hit         <= 1'b0;
                  state           <= RESP;
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/buf_lru_alloc_ctrl.md
Name: buf_lru_alloc_ctrl

Overview:
- Shares a pool of 4 buffers between two requesters; each request carries a tag.
- Looks the tag up in an internal 4-entry tag table.
  - Hit: returns the buffer number.
  - Miss: picks a victim (lowest invalid entry, else the least-recently-used buffer), runs a fill handshake with the backing store, then returns the victim.
- Sits between the requester ports and the buffer RAM/fill engine.
- Embeds the 6-bit pairwise LRU ordering used across the buffer subsystem.

Parameters:
TAG_W, 8, width of request/fill tags

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  2  bit i: requester i has a request
req_tag0  in  TAG_W  tag from requester 0
req_tag1  in  TAG_W  tag from requester 1
req_ready  out  2  one-hot grant; request i accepted when req_valid[i] & req_ready[i]
flush  in  1  pulse: invalidate all tag entries
rsp_valid  out  1  one-cycle response strobe
rsp_id  out  1  requester the response belongs to
rsp_buf  out  2  buffer number assigned
rsp_hit  out  1  1 = tag hit, 0 = filled on miss
fill_req  out  1  fill request, held until fill_done
fill_buf  out  2  buffer to fill
fill_tag  out  TAG_W  tag to fill
fill_done  in  1  fill complete, sampled only while fill_req=1
busy  out  1  1 in every state except IDLE

Behaviour:
- Clock and reset: one clock domain; rst_n is asynchronous, active-low.
- Reset values:
  - state IDLE.
  - All outputs 0.
  - Valid bits 0000, tags 0.
  - LRU = 6'b111111 (order 0 oldest, 1, 2, 3 newest).
  - Round-robin pointer favours requester 0.
  - Flush-pending flag 0.
  - Reset mid-FILL drops fill_req immediately; an in-flight fill is abandoned.
- LRU encoding, one bit per pair, 1 = lower index older:
  - bit5=(0,1), bit4=(0,2), bit3=(0,3), bit2=(1,2), bit1=(1,3), bit0=(2,3).
  - Touch buffer k: every pair (i,k) with i<k is set to 1; every pair (k,j) with j>k is cleared to 0; all other bits are unchanged.
  - Oldest buffer: the one that is older in all three of its pairs.
  - Only reachable values are produced; any unreachable value selects buffer 0.
- IDLE:
  - Flush pending or flush=1: clear all valid bits and the pending flag; no grant this cycle; LRU unchanged.
  - Otherwise, any req_valid set: req_ready is driven combinationally one-hot for the winner in the same cycle.
  - Both requesting: the requester not granted last wins; after reset, 0 wins.
  - On grant: latch tag and id, update the RR pointer, go to LOOKUP.
  - req_ready is 0 in all other states.
- LOOKUP (1 cycle): compare the latched tag against valid entries.
  - Hit on buffer h: touch h; rsp_buf=h, rsp_hit=1; go to RESP.
  - Miss: victim = lowest-index invalid entry, else the LRU oldest; go to FILL.
- FILL:
  - fill_req=1, fill_buf=victim and fill_tag=tag, all stable throughout FILL.
  - On fill_done: entry[victim] valid, tag written, touch victim; rsp_buf=victim, rsp_hit=0; go to RESP.
  - fill_done outside FILL is ignored.
- RESP: rsp_valid=1 with rsp_id, rsp_buf and rsp_hit for exactly one cycle, then IDLE.
  - rsp_buf, rsp_id and rsp_hit hold their values until the next response.
- Latency:
  - Grant in cycle T.
  - Hit: rsp_valid in T+2.
  - Miss: fill_req high from T+2; fill_done in cycle F gives rsp_valid in F+1.
- Flush while busy: sets the pending flag and is applied on the next IDLE cycle, before any grant. A fill completing in the same operation still writes its entry, and the pending flush then clears it.
- Duplicate tags cannot arise: one operation runs at a time and a miss always fills.
- Requests not granted stay pending; requesters hold req_valid and their tag until granted.

Test Plan:
- Reset, req_valid=01, tag0=8'h11, fill_done 3 cycles after fill_req -> fill_buf=0, then rsp_valid with rsp_buf=0, rsp_hit=0, rsp_id=0; repeat tag 8'h11 -> rsp_hit=1, rsp_buf=0 at T+2, no fill_req.
- Fill tags 8'hA0..8'hA3 into buffers 0..3, then hit 8'hA0, then miss 8'hB0 -> victim = buffer 1 (LRU oldest), fill_buf=1; LRU after = buffer 1 newest.
- req_valid=11 held continuously -> grants alternate 0, 1, 0, 1, starting with 0 after reset; rsp_id follows the same order.
- Pulse flush during FILL -> current response still completes; next request with the same tag misses and refills into buffer 0.
- Assert rst_n=0 while fill_req=1 -> fill_req, busy and rsp_valid go to 0 without waiting for a clock edge; after release, the first request misses into buffer 0.
- Drive fill_done in IDLE and LOOKUP -> no state change and no response.
